// File: rtl/counter_seq_ctrl_if.sv
// Job command channel between the requester logic and counter_seq_ctrl.
// The requester drives the job fields and CMD_VALID; the controller returns CMD_READY.
interface counter_seq_ctrl_if #(
  parameter int unsigned WRAP_W = 4
);
  logic              CMD_VALID;
  logic              CMD_READY;
  logic [1:0]        CMD_MODO;
  logic [3:0]        CMD_D;
  logic [WRAP_W-1:0] CMD_WRAPS;

  modport master (
    output CMD_VALID,
    output CMD_MODO,
    output CMD_D,
    output CMD_WRAPS,
    input  CMD_READY
  );

  modport slave (
    input  CMD_VALID,
    input  CMD_MODO,
    input  CMD_D,
    input  CMD_WRAPS,
    output CMD_READY
  );
endinterface

// File: rtl/counter_seq_ctrl.sv
// Sequencer for a 4-bit multi-mode counter.
// Accepts a job, preloads the counter, checks the load, runs the counter
// until the requested number of wrap-arounds, then pulses DONE (or ERR).
module counter_seq_ctrl #(
  parameter int unsigned WRAP_W = 4
) (
  input  logic              clk,
  input  logic              RESET,
  counter_seq_ctrl_if.slave cmd,
  input  logic              ABORT,
  input  logic [3:0]        CNT_Q,
  input  logic              CNT_LOAD,
  output logic              CNT_ENABLE,
  output logic [1:0]        CNT_MODO,
  output logic [3:0]        CNT_D,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR,
  output logic [WRAP_W-1:0] WRAP_CNT
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [1:0]        mode_reg;
  logic [3:0]        d_reg;
  logic [WRAP_W-1:0] wraps_reg;
  logic [WRAP_W-1:0] wrap_cnt;
  logic [WRAP_W-1:0] wrap_inc;
  logic              err_q;
  logic              accept;
  logic              load_ok;
  logic              wrap_hit;
  logic              last_wrap;

  assign cmd.CMD_READY = (state == S_IDLE) && !RESET;
  assign accept        = cmd.CMD_VALID && cmd.CMD_READY;
  assign load_ok       = CNT_LOAD && (CNT_Q == d_reg);
  assign wrap_inc      = wrap_cnt + WRAP_W'(1);
  assign last_wrap     = wrap_hit && (wrap_inc == wraps_reg);

  assign ERR      = err_q;
  assign WRAP_CNT = wrap_cnt;

  // Terminal-count detect for the mode being run
  always_comb begin
    wrap_hit = 1'b0;
    unique case (mode_reg)
      2'b00:   wrap_hit = (CNT_Q == 4'hF);
      2'b01:   wrap_hit = (CNT_Q == 4'h0);
      2'b10:   wrap_hit = (CNT_Q <= 4'h2);
      default: wrap_hit = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic and state-decoded counter controls
  always_comb begin
    state_nxt  = state;
    CNT_ENABLE = 1'b0;
    CNT_MODO   = 2'b00;
    CNT_D      = '0;
    BUSY       = (state != S_IDLE);
    DONE       = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        CNT_ENABLE = 1'b1;
        CNT_MODO   = 2'b11;
        CNT_D      = d_reg;
        state_nxt  = ABORT ? S_IDLE : S_CHECK;
      end
      S_CHECK: begin
        CNT_ENABLE = 1'b1;
        CNT_MODO   = 2'b11;
        CNT_D      = d_reg;
        if (ABORT)                                     state_nxt = S_IDLE;
        else if (!load_ok)                             state_nxt = S_IDLE;
        else if (mode_reg == 2'b11 || wraps_reg == '0) state_nxt = S_DONE;
        else                                           state_nxt = S_RUN;
      end
      S_RUN: begin
        CNT_ENABLE = 1'b1;
        CNT_MODO   = mode_reg;
        if (ABORT)          state_nxt = S_IDLE;
        else if (last_wrap) state_nxt = S_DONE;
      end
      S_DONE: begin
        DONE      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Job fields, wrap counter and the ERR pulse
  // ERR is registered so it appears in the first IDLE cycle after a failed check,
  // keeping CNT_LOAD/CNT_Q off any combinational path to the outputs.
  always_ff @(posedge clk) begin
    if (RESET) begin
      mode_reg  <= '0;
      d_reg     <= '0;
      wraps_reg <= '0;
      wrap_cnt  <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= (state == S_CHECK) && !ABORT && !load_ok;
      if (accept) begin
        mode_reg  <= cmd.CMD_MODO;
        d_reg     <= cmd.CMD_D;
        wraps_reg <= cmd.CMD_WRAPS;
        wrap_cnt  <= '0;
      end else if ((state == S_RUN) && !ABORT && wrap_hit && (wrap_cnt != wraps_reg)) begin
        wrap_cnt <= wrap_inc;
      end
    end
  end

endmodule
